call_queue: RTL
===============

Name: call_queue

Overview:
- Upstream stage of the elevator controller `ele_ctrl`.
- Synchronises raw floor-call buttons and latches each press as a pending call until it is served.
- Drives `ele_ctrl`'s `req[3:0]` with a single one-hot target at a time, chosen as the nearest pending floor.
- On arrival, holds the door open for a fixed dwell time and clears the served call.

Parameters:
- DWELL_CYC, 8, door-open dwell length in clk cycles (legal range 1..255)
- SYNC_STAGES, 2, synchroniser depth on the button inputs (legal range 2..3)

Ports:
- clk  input  1  system clock; all flops on the rising edge
- rst_n  input  1  asynchronous reset, active-low
- btn  input  4  raw asynchronous call buttons, bit f = floor f (0 = ground)
- curr_flr  input  2  current floor, from `ele_ctrl`
- moving  input  1  transition pulse, from `ele_ctrl`
- req  output  4  one-hot target request to `ele_ctrl`; all-zero when there is no target
- door_open  output  1  high during the dwell at the served floor
- pend  output  4  pending-call bitmap (debug/status)
- busy  output  1  high when the FSM is not IDLE

Behaviour:
- Reset (rst_n low, asynchronous): req=0, door_open=0, pend=0, busy=0, FSM=IDLE, dwell counter=0, all synchroniser/edge flops=0.
- Input path: btn[f] passes through SYNC_STAGES flops, then a rising-edge detect (sync output high, previous sample low).
  - A held button registers exactly once.
  - Latency from btn stable high before edge k to pend[f] set: visible after edge k+SYNC_STAGES (3 edges total with the default).
- Pending set/clear rules:
  - An edge on floor f sets pend[f], except in the two cases below.
  - Arrival clear of pend[f] and an edge on floor f in the same cycle: clear wins, and the press is dropped.
  - A press for curr_flr while in DWELL does not set pend. It reloads the dwell counter (extends the door-open time).
- Target select (combinational, from pend and curr_flr): the pending floor with minimum |f − curr_flr|; a tie picks the lower floor.
- FSM:
  - IDLE
    - pend==0: stay.
    - Otherwise latch target and go to SERVE.
    - If the selected target==curr_flr, go directly to the arrival action instead.
  - SERVE
    - req = onehot(target); the target is frozen while in SERVE.
    - New presses accumulate in pend only.
    - Arrival condition: moving==0 && curr_flr==target.
    - On arrival: pend[target] cleared, req←0, door_open←1, counter←DWELL_CYC−1, go to DWELL.
    - Because the controller's curr_flr lags its internal state by one cycle, arrival is recognised on the first cycle after the moving pulse.
  - DWELL
    - req=0 (the controller must stay put); door_open=1.
    - Counter decrements each cycle.
    - At counter==0: door_open←0, then go to SERVE with a freshly selected target if pend≠0, else IDLE.
    - door_open is high exactly DWELL_CYC cycles when no reload occurs.
- busy = (FSM≠IDLE).
- req is registered, never multi-hot, and never asserted while door_open=1.
- Reset mid-operation discards all pending calls and the dwell; the controller sees req=0 immediately.

Decomposition:
- Shared package/include `ele_pkg`:
  - floor constants FLOOR_G..FLOOR_3 (2'b00..2'b11)
  - NUM_FLR=4
  - FSM state encodings IDLE/SERVE/DWELL
- One sub-module `btn_sync`: a 1-bit SYNC_STAGES-deep synchroniser plus rising-edge pulse, instantiated 4×.
- Target select and FSM stay in `call_queue`.

Test Plan:
Bench connects `call_queue` to the `ele_ctrl` model, with the controller's reset driven from ~rst_n.
- Reset, then btn=4'b0000 for 20 cycles: req=0, pend=0, door_open=0, busy=0 throughout.
- From floor 0, pulse btn[2] for 1 cycle: pend=4'b0100 three edges later, then req=4'b0100.
  - After the controller's moving pulse, curr_flr=2 and door_open is high for 8 cycles.
  - pend=0, and the FSM returns to IDLE.
- From floor 1, press btn[0] and btn[3] in the same cycle: the first target is floor 0 (distance 1 < 2), req=4'b0001.
  - After its dwell, req=4'b1000 and the car reaches floor 3.
- Hold btn[1] high for 50 cycles while idle at floor 0: exactly one service of floor 1 (a single dwell), with no re-request.
- During DWELL at floor 2, press btn[2] at counter=2: the counter reloads to 7, door_open stays high 8 more cycles, and pend[2] stays 0.
- While req=4'b1000 and the car is mid-trip, assert rst_n=0 for 1 cycle: req, pend, door_open and busy are all 0 on the same cycle; no call is served afterwards.

Source files
------------

// File: rtl/ele_pkg.sv
// ---------------------------------------------------------------------------
// ele_pkg
// Shared definitions for the elevator front-end (call_queue) and the
// elevator controller it feeds (ele_ctrl).
//   - floor encodings FLOOR_G..FLOOR_3 and the floor count NUM_FLR
//   - call_queue FSM state encoding (IDLE / SERVE / DWELL)
//   - small helpers: floor -> one-hot request, floor distance
// ---------------------------------------------------------------------------
package ele_pkg;

  localparam int NUM_FLR = 4;

  localparam logic [1:0] FLOOR_G = 2'b00;
  localparam logic [1:0] FLOOR_1 = 2'b01;
  localparam logic [1:0] FLOOR_2 = 2'b10;
  localparam logic [1:0] FLOOR_3 = 2'b11;

  // IDLE  : no target, req low
  // SERVE : one frozen target, req = onehot(target) until the car arrives
  // DWELL : door open at the served floor, req low
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DWELL = 2'd2
  } cq_state_e;

  // One-hot request vector for a floor number.
  function automatic logic [NUM_FLR-1:0] flr_onehot(input logic [1:0] flr);
    logic [NUM_FLR-1:0] v;
    v      = '0;
    v[flr] = 1'b1;
    return v;
  endfunction

  // Absolute distance between two floors.
  function automatic logic [1:0] flr_dist(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/btn_sync.sv
// ---------------------------------------------------------------------------
// btn_sync
// One raw asynchronous button bit brought into the clk domain through a
// SYNC_STAGES-deep flop chain, followed by a rising-edge detector. A button
// held high produces exactly one o_rise pulse.
//
// Ports:
//   clk     in   system clock (rising edge)
//   rst_n   in   asynchronous active-low reset; clears chain and edge flop
//   i_btn   in   raw asynchronous button
//   o_rise  out  one-cycle pulse: synchronised level high, previous sample low
// ---------------------------------------------------------------------------
module btn_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_level;

  assign w_level = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
      r_prev <= w_level;
    end
  end

  // Combinational pulse from the last sync stage: with two stages the pulse
  // is visible in the cycle after the second edge, so the pending bit that
  // captures it lands on the third edge.
  assign o_rise = w_level & ~r_prev;

endmodule

// File: rtl/call_queue.sv
// ---------------------------------------------------------------------------
// call_queue
// Upstream stage of the elevator controller ele_ctrl. Latches floor-call
// presses as pending calls, sends the controller one target at a time (the
// nearest pending floor, ties to the lower floor), and holds the door open
// for DWELL_CYC cycles once the car arrives, clearing the served call.
//
// Request/arrival handshake with ele_ctrl: req is a registered one-hot level
// that stays constant for the whole trip (the target is frozen in SERVE). The
// controller signals progress with a one-cycle moving pulse per floor and
// updates curr_flr one cycle later; the request is complete on the first
// cycle with moving==0 and curr_flr==target, and req drops on that edge.
// req is never multi-hot and is never high while door_open is high.
//
// Ports:
//   clk        in   system clock (rising edge)
//   rst_n      in   asynchronous active-low reset
//   btn[3:0]   in   raw asynchronous call buttons, bit f = floor f
//   curr_flr   in   current floor from ele_ctrl
//   moving     in   per-floor transition pulse from ele_ctrl
//   req[3:0]   out  one-hot target request, zero when no target
//   door_open  out  high during the dwell at the served floor
//   pend[3:0]  out  pending-call bitmap
//   busy       out  FSM not in IDLE (state visibility)
// ---------------------------------------------------------------------------
module call_queue
  import ele_pkg::*;
#(
  parameter int DWELL_CYC   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   btn,
  input  logic [1:0]   curr_flr,
  input  logic         moving,
  output logic [3:0]   req,
  output logic         door_open,
  output logic [3:0]   pend,
  output logic         busy
);

  localparam logic [7:0] LP_RELOAD = 8'(DWELL_CYC - 1);

  // ---------------------------------------------------------------- inputs
  logic [NUM_FLR-1:0] w_edge;

  for (genvar g = 0; g < NUM_FLR; g++) begin : g_sync
    btn_sync #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_btn_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_btn  (btn[g]),
      .o_rise (w_edge[g])
    );
  end

  // ----------------------------------------------------------------- state
  cq_state_e          r_state;
  logic [1:0]         r_target;
  logic [7:0]         r_cnt;
  logic [NUM_FLR-1:0] r_req;
  logic               r_door;
  logic [NUM_FLR-1:0] r_pend;

  cq_state_e          w_state_nxt;
  logic [1:0]         w_target_nxt;
  logic [7:0]         w_cnt_nxt;
  logic [NUM_FLR-1:0] w_req_nxt;
  logic               w_door_nxt;
  logic [NUM_FLR-1:0] w_pend_nxt;
  logic [NUM_FLR-1:0] w_clr;    // arrival clear mask
  logic [NUM_FLR-1:0] w_blk;    // presses that must not reach pend

  // --------------------------------------------------------- target select
  // Scan upward and only replace on a strictly smaller distance, so a tie
  // keeps the lower floor.
  logic       w_sel_valid;
  logic [1:0] w_sel_flr;
  logic [1:0] w_best_dist;

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_flr   = FLOOR_G;
    w_best_dist = 2'd3;
    for (int f = 0; f < NUM_FLR; f++) begin
      if (r_pend[f] && (!w_sel_valid || (flr_dist(2'(f), curr_flr) < w_best_dist))) begin
        w_sel_valid = 1'b1;
        w_sel_flr   = 2'(f);
        w_best_dist = flr_dist(2'(f), curr_flr);
      end
    end
  end

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_target <= FLOOR_G;
      r_cnt    <= '0;
      r_req    <= '0;
      r_door   <= 1'b0;
      r_pend   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_target <= w_target_nxt;
      r_cnt    <= w_cnt_nxt;
      r_req    <= w_req_nxt;
      r_door   <= w_door_nxt;
      r_pend   <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    w_cnt_nxt    = r_cnt;
    w_req_nxt    = r_req;
    w_door_nxt   = r_door;
    w_clr        = '0;
    w_blk        = '0;

    unique case (r_state)
      IDLE: begin
        w_req_nxt  = '0;
        w_door_nxt = 1'b0;
        if (w_sel_valid) begin
          w_target_nxt = w_sel_flr;
          if (w_sel_flr == curr_flr && !moving) begin
            // Call at the floor the car already stands on: open straight away.
            w_clr       = flr_onehot(w_sel_flr);
            w_door_nxt  = 1'b1;
            w_cnt_nxt   = LP_RELOAD;
            w_state_nxt = DWELL;
          end else begin
            w_req_nxt   = flr_onehot(w_sel_flr);
            w_state_nxt = SERVE;
          end
        end
      end

      SERVE: begin
        // curr_flr lags the controller by a cycle, so it only matches the
        // target once the moving pulse has dropped.
        if (!moving && curr_flr == r_target) begin
          w_clr       = flr_onehot(r_target);
          w_req_nxt   = '0;
          w_door_nxt  = 1'b1;
          w_cnt_nxt   = LP_RELOAD;
          w_state_nxt = DWELL;
        end
      end

      DWELL: begin
        // A press for the open floor extends the dwell instead of queueing
        // a call; it takes priority over closing on the same cycle.
        w_blk     = flr_onehot(curr_flr);
        w_req_nxt = '0;
        if (w_edge[curr_flr]) begin
          w_cnt_nxt = LP_RELOAD;
        end else if (r_cnt == 8'd0) begin
          w_door_nxt = 1'b0;
          if (w_sel_valid) begin
            w_target_nxt = w_sel_flr;
            w_req_nxt    = flr_onehot(w_sel_flr);
            w_state_nxt  = SERVE;
          end else begin
            w_state_nxt  = IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_req_nxt   = '0;
        w_door_nxt  = 1'b0;
      end
    endcase

    // Clear beats a same-cycle press on the served floor (press is dropped).
    w_pend_nxt = (r_pend | (w_edge & ~w_blk)) & ~w_clr;
  end

  // --------------------------------------------------------------- outputs
  assign req       = r_req;
  assign door_open = r_door;
  assign pend      = r_pend;
  assign busy      = (r_state != IDLE);

endmodule
